// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage valid/ready ALU (S1 operand capture, S2 result/flags).
// Optional flag generation is enabled by defining PIPELINED_ALU_FLAGS_EN; otherwise
// flags_o is tied to zero and no flag logic exists.
module pipelined_alu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] alu_o,
    output logic [3:0]       flags_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_LSR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_EQL = 3'b111;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_op_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_res_q;
    logic [CNT_W-1:0] count_q;

    logic             s1_adv;
    logic             s2_adv;
    logic             out_xfer;
    logic [WIDTH-1:0] res_d;
    logic [SHW-1:0]   shamt;

    // Stage advance conditions; in_ready is combinational from out_ready_i.
    always_comb begin
        out_xfer   = s2_valid_q & out_ready_i;
        s2_adv     = ~s2_valid_q | out_ready_i;
        s1_adv     = ~s1_valid_q | s2_adv;
        in_ready_o = s1_adv;
    end

    assign shamt = s1_b_q[SHW-1:0];

    // Result datapath driven from the S1 operands.
    always_comb begin
        res_d = '0;
        case (s1_op_q)
            OP_ADD:  res_d = s1_a_q + s1_b_q;
            OP_SUB:  res_d = s1_a_q - s1_b_q;
            OP_SLL:  res_d = s1_a_q << shamt;
            OP_LSR:  res_d = s1_a_q >> shamt;
            OP_AND:  res_d = s1_a_q & s1_b_q;
            OP_OR:   res_d = s1_a_q | s1_b_q;
            OP_XOR:  res_d = s1_a_q ^ s1_b_q;
            OP_EQL:  res_d = {{(WIDTH-1){1'b0}}, (s1_a_q == s1_b_q)};
            default: res_d = '0;
        endcase
    end

`ifdef PIPELINED_ALU_FLAGS_EN
    logic [3:0] flags_d;
    logic [3:0] s2_flags_q;

    // Flags {N, V, C, Z}; carry/borrow derived by unsigned compare to avoid a wide adder.
    always_comb begin
        flags_d    = '0;
        flags_d[3] = res_d[WIDTH-1];
        flags_d[0] = (res_d == '0);
        case (s1_op_q)
            OP_ADD: begin
                flags_d[1] = (res_d < s1_a_q);
                flags_d[2] = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                             (res_d[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                flags_d[1] = (s1_a_q < s1_b_q);
                flags_d[2] = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                             (res_d[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            default: ;
        endcase
    end

    // S2 flag register, loaded alongside the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_flags_q <= '0;
        end else if (s2_adv && s1_valid_q) begin
            s2_flags_q <= flags_d;
        end
    end

    assign flags_o = s2_flags_q;
`else
    assign flags_o = 4'b0000;
`endif

    // S1: capture operands whenever the stage can advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_a_q  <= a_i;
                s1_b_q  <= b_i;
                s1_op_q <= op_i;
            end
        end
    end

    // S2: hold the result until consumed; load only real operations.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q <= res_d;
            end
        end
    end

    // Completed-operation counter, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (out_xfer) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign alu_o       = s2_res_q;
    assign out_valid_o = s2_valid_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed testbench for pipelined_alu (WIDTH=8). Expected flags follow
// PIPELINED_ALU_FLAGS_EN: zero when the macro is undefined.
module tb_pipelined_alu;

    logic        clk;
    logic        reset_n;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic [2:0]  op_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  alu_o;
    logic [3:0]  flags_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] count_o;

    int tests = 0;
    int fails = 0;

    pipelined_alu #(
        .WIDTH(8),
        .CNT_W(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_i        (a_i),
        .b_i        (b_i),
        .op_i       (op_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .alu_o      (alu_o),
        .flags_o    (flags_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef PIPELINED_ALU_FLAGS_EN
        return f;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready high; leaves the result presented at posedge+1.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [7:0] er, input logic [3:0] ef);
        a_i = a;
        b_i = b;
        op_i = op;
        in_valid_i = 1'b1;
        check({tag, "_rdy"}, in_ready_o, 1'b1);
        step();
        in_valid_i = 1'b0;
        check({tag, "_lat1"}, out_valid_o, 1'b0);
        step();
        check({tag, "_vld"}, out_valid_o, 1'b1);
        check({tag, "_res"}, alu_o, er);
        check({tag, "_flg"}, flags_o, fx(ef));
    endtask

    initial begin
        reset_n = 1'b0;
        a_i = '0;
        b_i = '0;
        op_i = '0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        #12;
        check("rst_vld", out_valid_o, 1'b0);
        check("rst_alu", alu_o, 8'h00);
        check("rst_flg", flags_o, 4'b0000);
        check("rst_cnt", count_o, 16'd0);
        reset_n = 1'b1;
        step();
        check("rst_rdy", in_ready_o, 1'b1);

        // Directed single ops
        out_ready_i = 1'b1;
        run_op("add_ff01", 8'hFF, 8'h01, 3'b000, 8'h00, 4'b0011);
        run_op("add_7f01", 8'h7F, 8'h01, 3'b000, 8'h80, 4'b1100);
        run_op("sub_8001", 8'h80, 8'h01, 3'b001, 8'h7F, 4'b0100);
        run_op("sub_0102", 8'h01, 8'h02, 3'b001, 8'hFF, 4'b1010);
        run_op("sll_810b", 8'h81, 8'h0B, 3'b010, 8'h08, 4'b0000);
        run_op("lsr_8107", 8'h81, 8'h07, 3'b011, 8'h01, 4'b0000);
        run_op("eql_eq",   8'h5A, 8'h5A, 3'b111, 8'h01, 4'b0000);
        run_op("eql_ne",   8'h5A, 8'h5B, 3'b111, 8'h00, 4'b0001);
        run_op("and",      8'hF0, 8'h3C, 3'b100, 8'h30, 4'b0000);
        run_op("or",       8'hF0, 8'h0F, 3'b101, 8'hFF, 4'b1000);
        run_op("xor",      8'hAA, 8'hAA, 3'b110, 8'h00, 4'b0001);
        step();
        check("cnt_11", count_o, 16'd11);
        check("idle_vld", out_valid_o, 1'b0);

        // Asynchronous reset mid-cycle clears counter
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_cnt", count_o, 16'd0);
        #2;
        reset_n = 1'b1;
        step();

        // Backpressure: 4 ops, out_ready low
        out_ready_i = 1'b0;
        a_i = 8'd1; b_i = 8'd1; op_i = 3'b000; in_valid_i = 1'b1;
        check("bp_rdy0", in_ready_o, 1'b1);
        step();
        a_i = 8'd2; b_i = 8'd2;
        check("bp_rdy1", in_ready_o, 1'b1);
        step();
        check("bp_full_rdy", in_ready_o, 1'b0);
        check("bp_vld", out_valid_o, 1'b1);
        check("bp_res0", alu_o, 8'd2);
        a_i = 8'd3; b_i = 8'd3;
        step();
        check("bp_hold_res", alu_o, 8'd2);
        check("bp_hold_rdy", in_ready_o, 1'b0);
        check("bp_count0", count_o, 16'd0);
        out_ready_i = 1'b1;
        #1;
        check("bp_comb_rdy", in_ready_o, 1'b1);
        step();
        check("bp_res1", alu_o, 8'd4);
        a_i = 8'd4; b_i = 8'd4;
        step();
        in_valid_i = 1'b0;
        check("bp_res2", alu_o, 8'd6);
        step();
        check("bp_res3", alu_o, 8'd8);
        check("bp_vld3", out_valid_o, 1'b1);
        step();
        check("bp_empty", out_valid_o, 1'b0);
        check("bp_count", count_o, 16'd4);

        // Fill both stages, then reset asynchronously
        out_ready_i = 1'b0;
        a_i = 8'h10; b_i = 8'h10; op_i = 3'b000; in_valid_i = 1'b1;
        step();
        a_i = 8'h20; b_i = 8'h20;
        step();
        in_valid_i = 1'b0;
        check("full_vld", out_valid_o, 1'b1);
        check("full_rdy", in_ready_o, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("frst_vld", out_valid_o, 1'b0);
        check("frst_cnt", count_o, 16'd0);
        check("frst_alu", alu_o, 8'h00);
        #2;
        reset_n = 1'b1;
        step();
        out_ready_i = 1'b1;
        run_op("post_rst", 8'h05, 8'h06, 3'b000, 8'h0B, 4'b0000);
        step();
        check("post_cnt", count_o, 16'd1);
        check("post_empty", out_valid_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
